// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared AXI4 encodings, burst-master FSM states and the
//                beat-size helper used by the burst master and its bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // AxSIZE encoding for a full-width beat: log2 of the bytes per beat.
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_master_if
//  Description : AXI4 AW/W/B/AR/R bundle between the burst master and a
//                responder, with master and slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_burst_master_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [ID_WIDTH-1:0]     awid;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [ID_WIDTH-1:0]     arid;

    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst, arid,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst, arid,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready
    );

endinterface
`default_nettype wire

// File: rtl/axi_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_beat_counter
//  Description : 8-bit data-beat counter with synchronous clear and a flag
//                raised while the count equals the burst length (beats-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_beat_counter (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       clr,
    input  wire logic       en,
    input  wire logic [7:0] len,
    output logic            last
);

    logic [7:0] cnt;

    // Count accepted beats; clear wins so a new command always starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign last = (cnt == len);

endmodule
`default_nettype wire

// File: rtl/axi_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi_burst_master
//  Description : AXI4 initiator turning one command into a single INCR burst
//                on AW/W/B or AR/R; one transaction outstanding at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_LEN    = 255
) (
    input  wire logic                  clk,
    input  wire logic                  rst,

    input  wire logic                  cmd_valid,
    output logic                       cmd_ready,
    input  wire logic                  cmd_write,
    input  wire logic [ADDR_WIDTH-1:0] cmd_addr,
    input  wire logic [7:0]            cmd_len,

    input  wire logic [DATA_WIDTH-1:0] wr_data,
    input  wire logic                  wr_valid,
    output logic                       wr_ready,

    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    input  wire logic                  rd_ready,
    output logic                       rd_last,

    output logic                       done,
    output logic [1:0]                 done_resp,
    output logic                       done_err,

    axi_burst_master_if.master         axi
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(BYTES);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic                  awvalid_q;
    logic                  arvalid_q;
    logic [1:0]            resp_acc;
    logic                  err_flag;

    logic                  accept;
    logic                  misaligned;
    logic                  too_long;
    logic                  crosses_4k;
    logic                  reject;
    logic [31:0]           burst_end;
    logic                  w_hs;
    logic                  r_hs;
    logic                  cnt_last;

    // Command legality is judged on the live command so a bad request goes
    // straight to DONE without ever touching the bus.
    assign accept     = cmd_valid && (state == ST_IDLE);
    assign burst_end  = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(BYTES);
    assign misaligned = |cmd_addr[ADDR_LSB-1:0];
    assign too_long   = 32'(cmd_len) > 32'(MAX_LEN);
    assign crosses_4k = burst_end > 32'd4096;
    assign reject     = misaligned || too_long || crosses_4k;

    // Address channels present the registered command.
    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = axi_size(DATA_WIDTH);
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awid    = '0;

    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = axi_size(DATA_WIDTH);
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arid    = '0;

    // Payload streams are passed through only while their data phase is active,
    // which also keeps W quiet until the AW handshake has happened.
    assign axi.wvalid  = (state == ST_W) && wr_valid;
    assign axi.wdata   = wr_data;
    assign axi.wstrb   = '1;
    assign axi.wlast   = (state == ST_W) && cnt_last;
    assign wr_ready    = (state == ST_W) && axi.wready;

    assign axi.bready  = (state == ST_B);

    assign axi.rready  = (state == ST_R) && rd_ready;
    assign rd_valid    = (state == ST_R) && axi.rvalid;
    assign rd_data     = axi.rdata;
    assign rd_last     = (state == ST_R) && axi.rlast;

    assign cmd_ready   = (state == ST_IDLE);
    assign done        = (state == ST_DONE);
    assign done_resp   = resp_acc;
    assign done_err    = err_flag;

    assign w_hs = axi.wvalid && axi.wready;
    assign r_hs = axi.rvalid && axi.rready;

    axi_beat_counter u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (w_hs || r_hs),
        .len  (len_q),
        .last (cnt_last)
    );

    // Burst sequencing: command acceptance, address phase, data phase,
    // response capture and the one-cycle completion state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= 8'd0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            resp_acc  <= AXI_RESP_OKAY;
            err_flag  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q   <= cmd_addr;
                        len_q    <= cmd_len;
                        resp_acc <= AXI_RESP_OKAY;
                        err_flag <= 1'b0;
                        if (reject) begin
                            resp_acc <= AXI_RESP_DECERR;
                            err_flag <= 1'b1;
                            state    <= ST_DONE;
                        end else if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            state     <= ST_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= ST_AR;
                        end
                    end
                end
                ST_AW: begin
                    if (axi.awready) begin
                        awvalid_q <= 1'b0;
                        state     <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs && cnt_last) begin
                        state <= ST_B;
                    end
                end
                ST_B: begin
                    if (axi.bvalid) begin
                        resp_acc <= axi.bresp;
                        state    <= ST_DONE;
                    end
                end
                ST_AR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        state     <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_hs) begin
                        if (axi.rresp > resp_acc) begin
                            resp_acc <= axi.rresp;
                        end
                        if (axi.rlast) begin
                            // rlast must land exactly on the final counted beat
                            if (!cnt_last) begin
                                err_flag <= 1'b1;
                            end
                            state <= ST_DONE;
                        end else if (cnt_last) begin
                            // responder overran the burst: flag it and keep draining
                            err_flag <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_burst_master
//  Description : Randomised scoreboard bench for axi_burst_master with an
//                AXI responder model and per-command expected traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_master;

    localparam int DW = 256;
    localparam int AW = 32;

    typedef struct { logic [31:0] addr; logic [7:0] len; } addr_t;
    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { logic [1:0] resp; logic err; } done_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_ready, rd_last;
    logic          done, done_err;
    logic [1:0]    done_resp;

    axi_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

    axi_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LEN(255)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done(done), .done_resp(done_resp), .done_err(done_err),
        .axi(axi)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int w_seen = 0;
    int axi_activity = 0;

    addr_t         exp_aw[$];
    addr_t         exp_ar[$];
    beat_t         exp_w[$];
    beat_t         exp_rd[$];
    done_t         exp_done[$];
    logic [DW-1:0] wr_src[$];

    logic [1:0] cfg_bresp      = 2'b00;
    int         cfg_rlast_beat = 0;
    int         cfg_bad_beat   = -1;
    logic [1:0] cfg_bad_resp   = 2'b00;
    bit         cfg_wready_one = 1'b1;
    bit         cfg_rd_toggle  = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] gen_rdata(input logic [31:0] addr, input int beat);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++)
            d[i*32 +: 32] = addr ^ (32'(beat) << 8) ^ (32'(i) << 24) ^ 32'h5A5A_0000;
        return d;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Responder model and scoreboard monitor: sample on the falling edge,
    // update responder drives just after the rising edge.
    initial begin : bus
        beat_t      eb;
        addr_t      ea;
        done_t      ed;
        bit         aw_hs, ar_hs, w_hs, wr_hs, wlast_hs, b_hs, r_hs, rlast_hs, rd_hs, rst_seen;
        logic [31:0] ar_addr_s;
        int         r_beat;
        bit         r_active;
        logic [31:0] r_addr;
        r_beat = 0; r_active = 0; r_addr = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 0; axi.rlast = 0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;
        forever begin
            @(negedge clk);
            rst_seen  = rst;
            aw_hs     = axi.awvalid && axi.awready;
            ar_hs     = axi.arvalid && axi.arready;
            w_hs      = axi.wvalid && axi.wready;
            wr_hs     = wr_valid && wr_ready;
            wlast_hs  = w_hs && axi.wlast;
            b_hs      = axi.bvalid && axi.bready;
            r_hs      = axi.rvalid && axi.rready;
            rlast_hs  = r_hs && axi.rlast;
            rd_hs     = rd_valid && rd_ready;
            ar_addr_s = axi.araddr;
            if (axi.awvalid || axi.arvalid || axi.wvalid) axi_activity++;

            if (done) begin
                if (exp_done.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done=1 expected no completion");
                end else begin
                    ed = exp_done.pop_front();
                    chk("done_resp", DW'(done_resp), DW'(ed.resp));
                    chk("done_err", DW'(done_err), DW'(ed.err));
                end
                done_cnt++;
            end
            if (aw_hs) begin
                if (exp_aw.size() == 0) begin
                    total++; bad++;
                    $display("FAIL aw_unexpected: got awaddr=%0h expected no AW", axi.awaddr);
                end else begin
                    ea = exp_aw.pop_front();
                    chk("awaddr", DW'(axi.awaddr), DW'(ea.addr));
                    chk("awlen", DW'(axi.awlen), DW'(ea.len));
                    chk("awsize_burst_id", DW'({axi.awsize, axi.awburst, axi.awid}), DW'({3'd5, 2'b01, 4'd0}));
                end
            end
            if (ar_hs) begin
                if (exp_ar.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ar_unexpected: got araddr=%0h expected no AR", axi.araddr);
                end else begin
                    ea = exp_ar.pop_front();
                    chk("araddr", DW'(axi.araddr), DW'(ea.addr));
                    chk("arlen", DW'(axi.arlen), DW'(ea.len));
                    chk("arsize_burst_id", DW'({axi.arsize, axi.arburst, axi.arid}), DW'({3'd5, 2'b01, 4'd0}));
                end
            end
            if (w_hs) begin
                chk("w_after_aw", DW'(exp_aw.size()), DW'(0));
                if (exp_w.size() == 0) begin
                    total++; bad++;
                    $display("FAIL w_unexpected: got wdata=%0h expected no W beat", axi.wdata);
                end else begin
                    eb = exp_w.pop_front();
                    chk("wdata", axi.wdata, eb.data);
                    chk("wlast", DW'(axi.wlast), DW'(eb.last));
                    chk("wstrb", DW'(axi.wstrb), DW'(32'hFFFF_FFFF));
                end
                w_seen++;
            end
            if (rd_hs) begin
                if (exp_rd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got rd_data=%0h expected no read beat", rd_data);
                end else begin
                    eb = exp_rd.pop_front();
                    chk("rd_data", rd_data, eb.data);
                    chk("rd_last", DW'(rd_last), DW'(eb.last));
                end
            end

            @(posedge clk);
            #1;
            if (rst_seen || rst) begin
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.arready = 0;
                axi.rvalid = 0; axi.rlast = 0; wr_valid = 0; r_active = 0; r_beat = 0;
                wr_src.delete();
            end else begin
                axi.awready = ($urandom % 2) == 0;
                axi.arready = ($urandom % 2) == 0;
                axi.wready  = cfg_wready_one ? 1'b1 : (($urandom % 2) == 0);
                if (wr_hs && wr_src.size() > 0) void'(wr_src.pop_front());
                if (!(wr_valid && !wr_hs)) begin
                    wr_valid = (wr_src.size() > 0) && (($urandom % 4) != 0);
                    wr_data  = (wr_src.size() > 0) ? wr_src[0] : '0;
                end
                if (b_hs) axi.bvalid = 0;
                if (wlast_hs) begin
                    axi.bvalid = 1;
                    axi.bresp  = cfg_bresp;
                end
                if (ar_hs) begin
                    r_active = 1; r_beat = 0; r_addr = ar_addr_s;
                end
                if (r_hs) begin
                    r_beat++;
                    if (rlast_hs) r_active = 0;
                end
                if (!(axi.rvalid && !r_hs)) begin
                    axi.rvalid = r_active && (($urandom % 3) != 0);
                    axi.rdata  = gen_rdata(r_addr, r_beat);
                    axi.rresp  = (r_beat == cfg_bad_beat) ? cfg_bad_resp : 2'b00;
                    axi.rlast  = (r_beat == cfg_rlast_beat);
                end
                rd_ready = cfg_rd_toggle ? !rd_ready : (($urandom % 4) != 0);
            end
        end
    end

    // Issue one command; expectations come from the command and responder config.
    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len, input bit wait_done);
        bit            rej;
        int            d0;
        int            n;
        done_t         ed;
        addr_t         ea;
        beat_t         eb;
        logic [DW-1:0] d;
        logic [1:0]    worst;
        logic [1:0]    rr;
        rej = ((addr % 32) != 0) || ((int'(addr % 4096) + (int'(len) + 1) * 32) > 4096);
        axi_activity = 0;
        ea.addr = addr; ea.len = len;
        if (rej) begin
            ed.resp = 2'b11; ed.err = 1'b1;
        end else if (wr) begin
            exp_aw.push_back(ea);
            for (int i = 0; i <= int'(len); i++) begin
                d = rand_data();
                wr_src.push_back(d);
                eb.data = d; eb.last = (i == int'(len));
                exp_w.push_back(eb);
            end
            ed.resp = cfg_bresp; ed.err = 1'b0;
        end else begin
            exp_ar.push_back(ea);
            worst = 2'b00;
            for (int b = 0; b <= cfg_rlast_beat; b++) begin
                rr = (b == cfg_bad_beat) ? cfg_bad_resp : 2'b00;
                if (rr > worst) worst = rr;
                eb.data = gen_rdata(addr, b); eb.last = (b == cfg_rlast_beat);
                exp_rd.push_back(eb);
            end
            ed.resp = worst; ed.err = (cfg_rlast_beat != int'(len));
        end
        exp_done.push_back(ed);
        d0 = done_cnt;
        @(posedge clk); #2;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1 within 200 cycles");
                break;
            end
        end
        @(posedge clk); #2;
        cmd_valid = 0; cmd_addr = $urandom; cmd_len = 8'($urandom);
        if (wait_done) begin
            n = 0;
            while (done_cnt == d0) begin
                @(negedge clk);
                n++;
                if (n > 3000) begin
                    total++; bad++;
                    $display("FAIL done_timeout: got no done expected done within 3000 cycles");
                    break;
                end
            end
            if (rej) chk("no_axi_on_reject", DW'(axi_activity), DW'(0));
        end
    endtask

    function automatic void default_cfg(input int len);
        cfg_bresp = 2'b00; cfg_rlast_beat = len; cfg_bad_beat = -1; cfg_bad_resp = 2'b00;
        cfg_wready_one = 1'b0; cfg_rd_toggle = 1'b0;
    endfunction

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got no finish expected finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stim
        int w0;
        int n;
        int len;
        logic [31:0] addr;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("reset_cmd_ready", DW'(cmd_ready), DW'(1));
        chk("reset_done", DW'({done, done_resp, done_err}), DW'(0));
        chk("reset_valids", DW'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, wr_ready, rd_valid}), DW'(0));

        // Directed: basic write with wready held high
        default_cfg(3); cfg_wready_one = 1;
        run_cmd(1, 32'h1000, 8'd3, 1);
        // Directed: read with rd_ready toggling
        default_cfg(7); cfg_rd_toggle = 1;
        run_cmd(0, 32'h2000, 8'd7, 1);
        // Directed: early rlast on the second beat, then a clean read
        default_cfg(3); cfg_rlast_beat = 1;
        run_cmd(0, 32'h3000, 8'd3, 1);
        default_cfg(3);
        run_cmd(0, 32'h3100, 8'd3, 1);
        // Directed: late rlast (one beat past the burst)
        default_cfg(2); cfg_rlast_beat = 3;
        run_cmd(0, 32'h3200, 8'd2, 1);
        // Directed: error responses
        default_cfg(1); cfg_bresp = 2'b10;
        run_cmd(1, 32'h4000, 8'd1, 1);
        default_cfg(3); cfg_bad_beat = 2; cfg_bad_resp = 2'b11;
        run_cmd(0, 32'h5000, 8'd3, 1);
        // Directed: 4KB crossing and misaligned commands are rejected
        default_cfg(1);
        run_cmd(1, 32'h0FE0, 8'd1, 1);
        repeat (3) @(negedge clk);
        chk("reject_resp_hold", DW'({done_resp, done_err}), DW'({2'b11, 1'b1}));
        run_cmd(0, 32'h1004, 8'd0, 1);
        // Boundary: a burst ending exactly on the 4KB line is legal
        default_cfg(1);
        run_cmd(1, 32'h0FC0, 8'd1, 1);

        // Directed: reset mid-write after two of eight beats
        default_cfg(7); cfg_wready_one = 1;
        w0 = w_seen;
        run_cmd(1, 32'h6000, 8'd7, 0);
        n = 0;
        forever begin
            @(posedge clk);
            if (w_seen - w0 >= 2) break;
            n++;
            if (n > 500) begin
                total++; bad++;
                $display("FAIL wbeat_timeout: got %0d beats expected 2", w_seen - w0);
                break;
            end
        end
        #2 rst = 1;
        #1;
        chk("reset_mid_burst_valids", DW'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, wr_ready, rd_valid, done}), DW'(0));
        exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_rd.delete(); exp_done.delete();
        @(posedge clk); #2 rst = 0;
        default_cfg(3);
        run_cmd(1, 32'h7000, 8'd3, 1);
        default_cfg(3);
        run_cmd(0, 32'h7100, 8'd3, 1);

        // Randomised commands, back to back
        for (int k = 0; k < 40; k++) begin
            len = $urandom % 16;
            if (($urandom % 8) == 0) addr = $urandom & 32'h0000_FFFC;
            else addr = (($urandom % 16) * 4096) + ($urandom_range(0, 127 - len) * 32);
            default_cfg(len);
            cfg_bresp = 2'($urandom);
            cfg_wready_one = ($urandom % 2) == 0;
            if (($urandom % 3) == 0) begin
                cfg_bad_beat = $urandom % (len + 1);
                cfg_bad_resp = 2'($urandom);
            end
            case ($urandom % 6)
                0: cfg_rlast_beat = len + 1;
                1: cfg_rlast_beat = (len > 0) ? len - 1 : len;
                default: cfg_rlast_beat = len;
            endcase
            run_cmd(($urandom % 2) == 1, addr, 8'(len), 1);
        end

        repeat (5) @(negedge clk);
        chk("queues_drained", DW'(exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size() + exp_done.size()), DW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
